// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered RISC-V immediate-decode stage between fetch and execute.
// Each accepted instruction is classified by immediate format. The stage produces the
// XLEN-wide sign-extended immediate and the PC-relative target.
// A main register plus a skid register keep full throughput when execute stalls.
// Optional feature macro: IMM_DECODE_CSR_UIMM_EN. When it is defined, CSR*I
// instructions report their 5-bit zero-extended uimm as format 6.

module imm_decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_target,
   output logic            out_illegal
);

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_CSR  = 3'd6
   } fmt_t;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      fmt_t            fmt;
      logic [XLEN-1:0] target;
      logic            illegal;
   } entry_t;

   entry_t          dec;
   entry_t          m_q;
   entry_t          s_q;
   logic            m_valid;
   logic            s_valid;
   logic signed [31:0] imm32;
   logic            pc_rel;
   logic            accept;
   logic            m_consumed;

   // Classify the incoming instruction and build its immediate as a 32-bit signed value.
   // The later XLEN cast sign-extends that value, so U-type bits 63:32 follow instr[31].
   always_comb begin
      imm32       = '0;
      pc_rel      = 1'b0;
      dec.instr   = in_instr;
      dec.pc      = in_pc;
      dec.fmt     = FMT_NONE;
      dec.illegal = 1'b0;
      case (in_instr[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: begin
            dec.fmt = FMT_I;
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         7'b1110011: begin
`ifdef IMM_DECODE_CSR_UIMM_EN
            if (in_instr[14]) begin
               dec.fmt = FMT_CSR;
               imm32   = {27'd0, in_instr[19:15]};
            end else begin
               dec.fmt = FMT_I;
               imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
`else
            dec.fmt = FMT_I;
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
`endif
         end
         7'b0100011: begin
            dec.fmt = FMT_S;
            imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         7'b1100011: begin
            dec.fmt = FMT_B;
            pc_rel  = 1'b1;
            imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
         end
         7'b0110111: begin
            dec.fmt = FMT_U;
            imm32   = {in_instr[31:12], 12'h000};
         end
         7'b0010111: begin
            dec.fmt = FMT_U;
            pc_rel  = 1'b1;
            imm32   = {in_instr[31:12], 12'h000};
         end
         7'b1101111: begin
            dec.fmt = FMT_J;
            pc_rel  = 1'b1;
            imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
         end
         7'b0110011, 7'b0001111: begin
            dec.fmt = FMT_NONE;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
      dec.imm    = XLEN'(imm32);
      dec.target = in_pc + (pc_rel ? dec.imm : XLEN'(4));
   end

   // Handshake terms. in_ready depends only on registered state and flush.
   always_comb begin
      in_ready   = !s_valid && !flush;
      accept     = in_valid && in_ready;
      m_consumed = m_valid && out_ready;
   end

   // Two-entry buffer. The skid entry refills the main register first. New entries go
   // to the main register when it is free or being drained, and to the skid otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_q     <= '0;
         s_q     <= '0;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (m_consumed && s_valid) begin
         m_q     <= s_q;
         s_valid <= 1'b0;
      end else if (accept && (!m_valid || m_consumed)) begin
         m_q     <= dec;
         m_valid <= 1'b1;
      end else if (accept) begin
         s_q     <= dec;
         s_valid <= 1'b1;
      end else if (m_consumed) begin
         m_valid <= 1'b0;
      end
   end

   // Outputs come straight from the main register.
   always_comb begin
      out_valid   = m_valid;
      out_instr   = m_q.instr;
      out_pc      = m_q.pc;
      out_imm     = m_q.imm;
      out_fmt     = m_q.fmt;
      out_target  = m_q.target;
      out_illegal = m_q.illegal;
   end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Testbench for imm_decode_stage. It drives an XLEN=32 and an XLEN=64 instance from the
// same inputs. A queue-based reference model predicts every output.
// Honours IMM_DECODE_CSR_UIMM_EN the same way the design does.

module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;

   logic        in_ready32, out_valid32, out_illegal32;
   logic [31:0] out_instr32, out_pc32, out_imm32, out_target32;
   logic [2:0]  out_fmt32;
   logic        in_ready64, out_valid64, out_illegal64;
   logic [31:0] out_instr64;
   logic [63:0] out_pc64, out_imm64, out_target64;
   logic [2:0]  out_fmt64;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } item_t;

   item_t q[$];

   imm_decode_stage #(.XLEN(32)) dut32 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32),
      .in_instr(in_instr), .in_pc(in_pc[31:0]),
      .out_valid(out_valid32), .out_ready(out_ready),
      .out_instr(out_instr32), .out_pc(out_pc32), .out_imm(out_imm32),
      .out_fmt(out_fmt32), .out_target(out_target32), .out_illegal(out_illegal32)
   );

   imm_decode_stage #(.XLEN(64)) dut64 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid64), .out_ready(out_ready),
      .out_instr(out_instr64), .out_pc(out_pc64), .out_imm(out_imm64),
      .out_fmt(out_fmt64), .out_target(out_target64), .out_illegal(out_illegal64)
   );

   always #5 clk = ~clk;

   // Reference decode written as arithmetic on the sign-extended instruction word.
   function automatic void ref_decode(input logic [31:0] ins, input logic [63:0] pc,
                                      input int xlen, output logic [63:0] imm,
                                      output logic [63:0] tgt, output logic [2:0] fmt,
                                      output logic ill);
      longint signed s, top, v;
      bit rel;
      s   = longint'($signed(ins));
      top = s >>> 31;
      v   = 0;
      rel = 0;
      fmt = 3'd0;
      ill = 1'b0;
      case (ins[6:0])
         7'h13, 7'h03, 7'h67: begin fmt = 3'd1; v = s >>> 20; end
         7'h73: begin
            fmt = 3'd1;
            v   = s >>> 20;
`ifdef IMM_DECODE_CSR_UIMM_EN
            if (ins[14]) begin fmt = 3'd6; v = longint'((ins >> 15) & 32'h1F); end
`endif
         end
         7'h23: begin fmt = 3'd2; v = (s >>> 25) * 32 + longint'((ins >> 7) & 32'h1F); end
         7'h63: begin
            fmt = 3'd3; rel = 1;
            v = top * 4096 + longint'((ins >> 7) & 32'h1) * 2048
                + longint'((ins >> 25) & 32'h3F) * 32 + longint'((ins >> 8) & 32'hF) * 2;
         end
         7'h37: begin fmt = 3'd4; v = (s >>> 12) * 4096; end
         7'h17: begin fmt = 3'd4; v = (s >>> 12) * 4096; rel = 1; end
         7'h6F: begin
            fmt = 3'd5; rel = 1;
            v = top * 1048576 + longint'((ins >> 12) & 32'hFF) * 4096
                + longint'((ins >> 20) & 32'h1) * 2048 + longint'((ins >> 21) & 32'h3FF) * 2;
         end
         7'h33, 7'h0F: fmt = 3'd0;
         default: ill = 1'b1;
      endcase
      imm = 64'(v);
      tgt = rel ? pc + imm : pc + 64'd4;
      if (xlen == 32) begin
         imm = imm & 64'hFFFF_FFFF;
         tgt = tgt & 64'hFFFF_FFFF;
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Compare both instances against the model at the falling edge, then advance the model at the rising edge.
   task automatic cycle(output bit acc);
      bit exp_rdy, cons;
      logic [63:0] imm, tgt;
      logic [2:0]  fmt;
      logic        ill;
      @(negedge clk);
      exp_rdy = (q.size() < 2) && !flush;
      chk("in_ready32", 64'(in_ready32), 64'(exp_rdy));
      chk("in_ready64", 64'(in_ready64), 64'(exp_rdy));
      chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
      chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
      if (q.size() > 0) begin
         ref_decode(q[0].instr, {32'd0, q[0].pc[31:0]}, 32, imm, tgt, fmt, ill);
         chk("instr32", 64'(out_instr32), 64'(q[0].instr));
         chk("pc32", 64'(out_pc32), {32'd0, q[0].pc[31:0]});
         chk("imm32", 64'(out_imm32), imm);
         chk("fmt32", 64'(out_fmt32), 64'(fmt));
         chk("target32", 64'(out_target32), tgt);
         chk("illegal32", 64'(out_illegal32), 64'(ill));
         ref_decode(q[0].instr, q[0].pc, 64, imm, tgt, fmt, ill);
         chk("instr64", 64'(out_instr64), 64'(q[0].instr));
         chk("pc64", out_pc64, q[0].pc);
         chk("imm64", out_imm64, imm);
         chk("fmt64", 64'(out_fmt64), 64'(fmt));
         chk("target64", out_target64, tgt);
         chk("illegal64", 64'(out_illegal64), 64'(ill));
      end
      acc  = in_valid && exp_rdy;
      cons = (q.size() > 0) && out_ready;
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (cons) void'(q.pop_front());
         if (acc) q.push_back('{instr: in_instr, pc: in_pc});
      end
      #1;
   endtask

   task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [63:0] pc);
      in_valid = v;
      in_instr = ins;
      in_pc    = pc;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                               7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};
      logic [31:0] r;
      int sel;
      r   = $urandom;
      sel = $urandom_range(0, 12);
      if (sel < 11) r[6:0] = ops[sel];
      else if (sel == 12) r[1:0] = 2'($urandom_range(0, 2));
      return r;
   endfunction

   // Directed sequence followed by a randomized phase.
   initial begin
      bit acc;
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
      applyStimulus(0, 32'd0, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_instr", 64'(out_instr32), 64'd0);
      chk("rst_pc", out_pc64, 64'd0);
      chk("rst_imm", out_imm64, 64'd0);
      chk("rst_fmt", 64'(out_fmt32), 64'd0);
      chk("rst_target", out_target64, 64'd0);
      chk("rst_illegal", 64'(out_illegal32), 64'd0);
      reset = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready32), 64'd1);
      chk("rst_out_valid", 64'(out_valid64), 64'd0);

      applyStimulus(1, 32'hFFF00093, 64'h0);
      cycle(acc);
      chk("addi_valid", 64'(out_valid32), 64'd1);
      chk("addi_imm", 64'(out_imm32), 64'hFFFF_FFFF);
      chk("addi_fmt", 64'(out_fmt32), 64'd1);
      chk("addi_target", 64'(out_target32), 64'h4);

      applyStimulus(1, 32'hFE000EE3, 64'h100);
      cycle(acc);
      chk("beq_imm", 64'(out_imm32), 64'hFFFF_FFFC);
      chk("beq_fmt", 64'(out_fmt32), 64'd3);
      chk("beq_target", 64'(out_target32), 64'hFC);
      applyStimulus(1, 32'h0010006F, 64'h1000);
      cycle(acc);
      chk("jal_imm", 64'(out_imm32), 64'h800);
      chk("jal_fmt", 64'(out_fmt32), 64'd5);
      chk("jal_target", 64'(out_target32), 64'h1800);

      applyStimulus(1, 32'h800000B7, 64'h0);
      cycle(acc);
      chk("lui64_imm", out_imm64, 64'hFFFF_FFFF_8000_0000);
      chk("lui64_fmt", 64'(out_fmt64), 64'd4);
      applyStimulus(1, 32'h00000000, 64'h0);
      cycle(acc);
      chk("zero_illegal", 64'(out_illegal64), 64'd1);
      chk("zero_fmt", 64'(out_fmt64), 64'd0);
      chk("zero_imm", out_imm64, 64'd0);

      applyStimulus(1, 32'h3002D073, 64'h40);
      cycle(acc);
`ifdef IMM_DECODE_CSR_UIMM_EN
      chk("csr_imm", 64'(out_imm32), 64'h5);
      chk("csr_fmt", 64'(out_fmt32), 64'd6);
`else
      chk("csr_imm", 64'(out_imm32), 64'h300);
      chk("csr_fmt", 64'(out_fmt32), 64'd1);
`endif
      applyStimulus(0, 32'd0, 64'd0);
      cycle(acc);

      // Backpressure: three offers with execute stalled.
      out_ready = 1'b0;
      applyStimulus(1, 32'h00A00113, 64'h200);
      cycle(acc);
      applyStimulus(1, 32'h00B00193, 64'h204);
      cycle(acc);
      applyStimulus(1, 32'h00C00213, 64'h208);
      cycle(acc);
      chk("bp_third_accepted", 64'(acc), 64'd0);
      chk("bp_in_ready", 64'(in_ready32), 64'd0);
      cycle(acc);
      out_ready = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 5 && !acc; i++) cycle(acc);
      chk("bp_third_eventually", 64'(acc), 64'd1);
      applyStimulus(0, 32'd0, 64'd0);
      repeat (4) cycle(acc);

      // Flush with two entries held and input offered.
      out_ready = 1'b0;
      applyStimulus(1, 32'h12345037, 64'h300);
      cycle(acc);
      applyStimulus(1, 32'h00000017, 64'h304);
      cycle(acc);
      flush = 1'b1;
      applyStimulus(1, 32'h0000006F, 64'h308);
      cycle(acc);
      chk("flush_dropped", 64'(acc), 64'd0);
      chk("flush_out_valid", 64'(out_valid32), 64'd0);
      flush = 1'b0;
      applyStimulus(0, 32'd0, 64'd0);
      #1;
      chk("flush_in_ready", 64'(in_ready64), 64'd1);
      cycle(acc);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         applyStimulus(bit'($urandom_range(0, 1)), rand_instr(), {$urandom, $urandom});
         cycle(acc);
      end
      flush = 1'b0;

      // Asynchronous reset with two entries buffered.
      out_ready = 1'b0;
      applyStimulus(1, rand_instr(), {$urandom, $urandom});
      cycle(acc);
      cycle(acc);
      applyStimulus(0, 32'd0, 64'd0);
      #2 reset = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid32), 64'd0);
      chk("arst_imm", out_imm64, 64'd0);
      q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      repeat (2) cycle(acc);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
